// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown display stage.
//   mode_t      - display mode FSM encoding (2 bit)
//   SEG_*       - active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } mode_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/countdown_display_seg7_decode.sv
// seg7_decode: combinational digit to 7-segment glyph.
//   digit in 4 : value 0-9; codes 10-15 produce a dash
//   seg   out 7: {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// countdown_display: display and alarm stage behind the countdown FSM.
// Drives a 2-digit multiplexed common-anode 7-segment display and a buzzer,
// tracking its own mode (idle / run / paused / alarm).
//   clk, rst  - 10 MHz clock, synchronous active-high reset
//   seconds   - remaining seconds 0-60 (61-63 invalid, shown as dashes)
//   running   - high while the countdown runs
//   clear_p   - one-cycle reset-key pulse
//   seg, dp   - active-low segments {g..a} and decimal point
//   an        - active-low anodes, an[0] = ones, an[1] = tens
//   buzzer    - tone output, active-high
//   alarm     - high while in ALARM mode
//
// Handshake: none; all inputs are level/pulse signals sampled every clock,
// all outputs are registered and valid every cycle after reset.
module countdown_display
  import countdown_pkg::*;
#(
  parameter int DIGIT_CYCLES      = 10_000,
  parameter int BLINK_HALF_CYCLES = 2_500_000,
  parameter int BEEP_HALF_CYCLES  = 2_500,
  parameter int ALARM_HALVES      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic       running,
  input  logic       clear_p,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       buzzer,
  output logic       alarm
);

  localparam int SCAN_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int BEEP_W  = (BEEP_HALF_CYCLES > 1) ? $clog2(BEEP_HALF_CYCLES) : 1;
  localparam int HALF_W  = $clog2(ALARM_HALVES + 1);

  mode_t              state, state_d;
  logic               running_q, running_qq;
  logic [5:0]         seconds_q;
  logic [1:0]         clr_hold;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               digit_sel;   // 0 = ones, 1 = tens
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [BEEP_W-1:0]  beep_cnt;
  logic [HALF_W-1:0]  halves;

  logic       rise, fall, sec_changed, blink_wrap, scan_wrap, beep_wrap;
  logic       enter_blink, blank;
  logic [2:0] tens;
  logic [5:0] ones6;
  logic [3:0] digit;
  logic [6:0] glyph;

  // Edges are taken on running_q so that a mode change lands one cycle
  // after the edge appears on running_q.
  assign rise        = running_q & ~running_qq;
  assign fall        = ~running_q & running_qq;
  assign sec_changed = (seconds != seconds_q);
  assign blink_wrap  = (blink_cnt == BLINK_W'(BLINK_HALF_CYCLES - 1));
  assign scan_wrap   = (scan_cnt == SCAN_W'(DIGIT_CYCLES - 1));
  assign beep_wrap   = (beep_cnt == BEEP_W'(BEEP_HALF_CYCLES - 1));

  // Mode FSM next state
  always_comb begin
    state_d = state;
    if (clear_p) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: if (rise) state_d = RUN;
        RUN: begin
          if (fall) begin
            // Upstream clear zeroes seconds before running drops; the
            // hold window keeps that from reading as an expired countdown.
            if (clr_hold != 2'd0)      state_d = IDLE;
            else if (seconds == 6'd0)  state_d = ALARM;
            else                       state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (rise)                    state_d = RUN;
          else if (seconds == 6'd0)    state_d = IDLE;
        end
        ALARM: begin
          if (rise)                    state_d = RUN;
          else if (sec_changed)        state_d = IDLE;
          else if (blink_wrap && halves == HALF_W'(ALARM_HALVES - 1))
                                       state_d = IDLE;
        end
        default:                       state_d = IDLE;
      endcase
    end
  end

  assign enter_blink = ((state_d == PAUSE) && (state != PAUSE)) ||
                       ((state_d == ALARM) && (state != ALARM));

  assign blank = ((state == PAUSE) || (state == ALARM)) && !blink_on;

  // BCD split by compare chain; the range check on ones6 also catches
  // any value the chain cannot represent.
  always_comb begin
    tens = 3'd0;
    if      (seconds >= 6'd60) tens = 3'd6;
    else if (seconds >= 6'd50) tens = 3'd5;
    else if (seconds >= 6'd40) tens = 3'd4;
    else if (seconds >= 6'd30) tens = 3'd3;
    else if (seconds >= 6'd20) tens = 3'd2;
    else if (seconds >= 6'd10) tens = 3'd1;
    ones6 = seconds - ({3'b000, tens} * 6'd10);
  end

  always_comb begin
    digit = 4'hF;
    if (seconds <= 6'd60 && ones6 <= 6'd9)
      digit = digit_sel ? {1'b0, tens} : ones6[3:0];
  end

  seg7_decode u_dec (
    .digit (digit),
    .seg   (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      running_q  <= 1'b0;
      running_qq <= 1'b0;
      seconds_q  <= 6'd0;
      clr_hold   <= 2'd0;
      scan_cnt   <= '0;
      digit_sel  <= 1'b0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      beep_cnt   <= '0;
      halves     <= '0;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= 2'b11;
      buzzer     <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_d;
      running_q  <= running;
      running_qq <= running_q;
      seconds_q  <= seconds;

      if (clear_p)                clr_hold <= 2'd3;
      else if (clr_hold != 2'd0)  clr_hold <= clr_hold - 2'd1;

      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_sel <= ~digit_sel;
      end else begin
        scan_cnt  <= scan_cnt + 1'b1;
      end

      // Blink phase restarts "on" whenever a blinking mode is entered.
      if (enter_blink) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_wrap) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if ((state_d == ALARM) && (state != ALARM))
        halves <= '0;
      else if ((state == ALARM) && blink_wrap)
        halves <= halves + 1'b1;

      if ((state == ALARM) && blink_on) begin
        if (beep_wrap) begin
          beep_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
        end
      end else begin
        beep_cnt <= '0;
        buzzer   <= 1'b0;
      end

      an    <= digit_sel ? 2'b01 : 2'b10;
      seg   <= blank ? SEG_BLANK : glyph;
      dp    <= !((state == RUN) && !digit_sel);
      alarm <= (state_d == ALARM);
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
module tb_countdown_display;

  localparam int DC = 4;
  localparam int BH = 16;
  localparam int BP = 2;
  localparam int AH = 4;

  localparam logic [11:0] M_ALL   = 12'hFFF;
  localparam logic [11:0] M_NODP  = 12'hFEF;
  localparam logic [11:0] M_NOBUZ = 12'hFFD;
  localparam logic [11:0] M_CTRL  = 12'h00F;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] seconds;
  logic       running;
  logic       clear_p;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       buzzer;
  logic       alarm;

  countdown_display #(
    .DIGIT_CYCLES      (DC),
    .BLINK_HALF_CYCLES (BH),
    .BEEP_HALF_CYCLES  (BP),
    .ALARM_HALVES      (AH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seconds (seconds),
    .running (running),
    .clear_p (clear_p),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .buzzer  (buzzer),
    .alarm   (alarm)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // scoreboard: {seg, dp, an, buzzer, alarm}
  logic [11:0] exp_q[$];
  logic [11:0] mask_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // n = cycles since reset release, 1 = first
  function automatic logic [1:0] exp_an(int n);
    return (((n - 1) / DC) % 2 == 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [6:0] exp_seg(int sec, int n, bit blank);
    if (blank) return 7'h7F;
    if (sec > 60) return 7'h3F;
    if (exp_an(n) == 2'b10) return glyph(sec % 10);
    return glyph(sec / 10);
  endfunction

  // j = edges since running fell (0 = first edge seeing the fall)
  function automatic bit blink_off(int j);
    return (j >= 2) && (((j - 2) / BH) % 2 == 1);
  endfunction

  function automatic logic exp_buz(int j);
    int h, l;
    if (j < 1 || j > AH * BH) return 1'b0;
    h = (j - 1) / BH;
    l = (j - 1) % BH;
    return (h % 2 == 0) && (l >= BP) && (((l - BP) / BP) % 2 == 0);
  endfunction

  task automatic push_exp(input logic [6:0] s, input logic d, input logic [1:0] a,
                          input logic b, input logic al, input logic [11:0] m);
    exp_q.push_back({s, d, a, b, al});
    mask_q.push_back(m);
  endtask

  task automatic tick(input string tag);
    logic [11:0] e, m, o;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    o = {seg, dp, an, buzzer, alarm};
    checks++;
    assert ((o & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s cyc=%0d {seg,dp,an,buz,alm} observed %h expected %h (mask %h)",
             tag, cyc, o, e, m);
    end
  endtask

  task automatic steady(input string tag, input int ncyc, input bit run_mode,
                        input logic [11:0] m);
    for (int i = 0; i < ncyc; i++) begin
      int n;
      n = cyc + 1;
      push_exp(exp_seg(int'(seconds), n, 1'b0),
               (run_mode && exp_an(n) == 2'b10) ? 1'b0 : 1'b1,
               exp_an(n), 1'b0, 1'b0, m);
      tick(tag);
    end
  endtask

  task automatic window(input string tag, input int len, input bit alarm_mode);
    for (int j = 0; j < len; j++) begin
      int n;
      n = cyc + 1;
      push_exp(exp_seg(int'(seconds), n, blink_off(j)), 1'b1, exp_an(n),
               alarm_mode ? exp_buz(j) : 1'b0,
               (alarm_mode && j >= 1 && j <= AH * BH) ? 1'b1 : 1'b0,
               (j < 2) ? M_NODP : M_ALL);
      tick(tag);
    end
  endtask

  task automatic reset_check(input string tag);
    push_exp(7'h7F, 1'b1, 2'b11, 1'b0, 1'b0, M_ALL);
    tick(tag);
  endtask

  initial begin
    rst = 1'b1; seconds = 6'd42; running = 1'b0; clear_p = 1'b0;
    repeat (3) reset_check("reset");
    rst = 1'b0;

    // idle scan of "42"
    steady("idle_42", 16, 1'b0, M_ALL);

    // run then pause with 17
    seconds = 6'd17; running = 1'b1;
    steady("rise_idle", 2, 1'b0, M_NODP);
    steady("run_17", 8, 1'b1, M_ALL);
    running = 1'b0;
    window("pause_17", 66, 1'b0);
    running = 1'b1;
    steady("rise_pause", 2, 1'b1, M_CTRL);
    steady("run_resume", 8, 1'b1, M_ALL);

    // countdown expires -> full alarm
    seconds = 6'd0;
    steady("run_00", 4, 1'b1, M_ALL);
    running = 1'b0;
    window("alarm_full", 67, 1'b1);

    // clear pulse suppresses the alarm
    seconds = 6'd5; running = 1'b1;
    steady("rise_idle2", 2, 1'b0, M_NODP);
    steady("run_05", 4, 1'b1, M_ALL);
    clear_p = 1'b1;
    steady("clear", 1, 1'b1, M_ALL);
    clear_p = 1'b0; seconds = 6'd0;
    steady("clear_sec0", 1, 1'b0, M_ALL);
    running = 1'b0;
    steady("suppressed", 70, 1'b0, M_ALL);

    // invalid and top-of-range values
    seconds = 6'd62;
    steady("dash_62", 10, 1'b0, M_ALL);
    seconds = 6'd63;
    steady("dash_63", 4, 1'b0, M_ALL);
    seconds = 6'd60;
    steady("sixty", 10, 1'b0, M_ALL);

    // alarm cancelled by a seconds change
    running = 1'b1;
    steady("rise_idle3", 2, 1'b0, M_NODP);
    seconds = 6'd0;
    steady("run_00b", 3, 1'b1, M_ALL);
    running = 1'b0;
    window("alarm_b", 6, 1'b1);
    seconds = 6'd1;
    steady("sec_change", 1, 1'b0, M_NOBUZ);
    steady("idle_after", 6, 1'b0, M_ALL);

    // reset in the middle of an alarm
    running = 1'b1;
    steady("rise_idle4", 2, 1'b0, M_NODP);
    seconds = 6'd0;
    steady("run_00c", 2, 1'b1, M_ALL);
    running = 1'b0;
    window("alarm_c", 8, 1'b1);
    rst = 1'b1;
    reset_check("rst_mid_alarm");
    rst = 1'b0;
    steady("after_rst", 4, 1'b0, M_ALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
